// File: rtl/barrel_distortion_correction_if.sv
// Pixel-stream bundle for barrel_distortion_correction: raster input side plus
// the backpressured corrected output side.
interface barrel_distortion_correction_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] pixel_in;
    logic                  pixel_valid;
    logic                  frame_start;
    logic                  frame_end;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] pixel_out;
    logic                  pixel_out_valid;
    logic                  frame_out_start;
    logic                  frame_out_end;

    modport master (
        output pixel_in, pixel_valid, frame_start, frame_end, out_ready,
        input  pixel_out, pixel_out_valid, frame_out_start, frame_out_end
    );

    modport slave (
        input  pixel_in, pixel_valid, frame_start, frame_end, out_ready,
        output pixel_out, pixel_out_valid, frame_out_start, frame_out_end
    );
endinterface

// File: rtl/barrel_distortion_correction.sv
// Frame-buffered inverse barrel correction: capture one raster frame, then stream
// it back out sampling each pixel at a radially contracted source coordinate.
module barrel_distortion_correction #(
    parameter int                    WIDTH      = 320,
    parameter int                    HEIGHT     = 466,
    parameter int                    DATA_WIDTH = 24,
    parameter logic [7:0]            CORR_K1    = 8'h40,
    parameter int                    K_SHIFT    = 8,
    parameter logic [DATA_WIDTH-1:0] FILL       = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    barrel_distortion_correction_if.slave  bus,
    output logic                           busy
);
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int AW     = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int STAGES = 5;
    localparam logic [AW-1:0]      LAST_ADDR = AW'(NPIX - 1);
    localparam logic [15:0]        XMAX = 16'(WIDTH - 1);
    localparam logic [15:0]        YMAX = 16'(HEIGHT - 1);
    localparam logic signed [16:0] CX   = 17'(WIDTH / 2);
    localparam logic signed [16:0] CY   = 17'(HEIGHT / 2);
    localparam logic signed [17:0] CX18 = 18'(WIDTH / 2);
    localparam logic signed [17:0] CY18 = 18'(HEIGHT / 2);

    typedef enum logic [1:0] {IDLE, RECEIVE, OUTPUT} state_t;
    state_t state, state_n;

    logic [DATA_WIDTH-1:0] mem [NPIX];
    logic [AW-1:0]         waddr, wr_addr;
    logic                  wr_en, advance, xfer;

    logic [STAGES:0]       vld_pipe, sof_pipe, eof_pipe;
    logic [15:0]           cnt_x, cnt_y, ox, oy;
    logic                  issue_done;

    logic signed [16:0]    s1_dx, s1_dy, s2_dx, s2_dy, s3_dx, s3_dy;
    logic [31:0]           s2_r2;
    logic [16:0]           s3_fac;
    logic signed [17:0]    s4_sx, s4_sy;
    logic [DATA_WIDTH-1:0] pix_q;

    assign advance = !vld_pipe[STAGES] || bus.out_ready;
    assign xfer    = vld_pipe[STAGES] && bus.out_ready;
    assign busy    = (state != IDLE);

    assign bus.pixel_out       = pix_q;
    assign bus.pixel_out_valid = vld_pipe[STAGES];
    assign bus.frame_out_start = sof_pipe[STAGES];
    assign bus.frame_out_end   = eof_pipe[STAGES];

    // Capture: the accepting frame_start pixel always lands at address 0.
    assign wr_en   = rst_n && bus.pixel_valid &&
                     ((state == IDLE && bus.frame_start) || state == RECEIVE);
    assign wr_addr = (state == IDLE) ? '0 : waddr;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.pixel_valid && bus.frame_start) state_n = RECEIVE;
            RECEIVE: if (bus.pixel_valid && (bus.frame_end || waddr == LAST_ADDR))
                         state_n = OUTPUT;
            OUTPUT:  if (xfer && bus.frame_out_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            waddr <= '0;
        end else begin
            state <= state_n;
            if (wr_en) waddr <= wr_addr + AW'(1);
        end
    end

    // Frame buffer survives reset so an early frame_end reuses old contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.pixel_in;
    end

    // Coordinate issue stage (vld_pipe[0]) and the valid/flag shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            sof_pipe   <= '0;
            eof_pipe   <= '0;
            cnt_x      <= '0;
            cnt_y      <= '0;
            ox         <= '0;
            oy         <= '0;
            issue_done <= 1'b0;
        end else begin
            if (state != OUTPUT) begin
                cnt_x      <= '0;
                cnt_y      <= '0;
                issue_done <= 1'b0;
            end
            if (advance) begin
                vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
                sof_pipe <= {sof_pipe[STAGES-1:0], 1'b0};
                eof_pipe <= {eof_pipe[STAGES-1:0], 1'b0};
                if (state == OUTPUT && !issue_done) begin
                    vld_pipe[0] <= 1'b1;
                    sof_pipe[0] <= (cnt_x == '0) && (cnt_y == '0);
                    eof_pipe[0] <= (cnt_x == XMAX) && (cnt_y == YMAX);
                    ox <= cnt_x;
                    oy <= cnt_y;
                    if (cnt_x == XMAX) begin
                        cnt_x <= '0;
                        if (cnt_y == YMAX) issue_done <= 1'b1;
                        else               cnt_y <= cnt_y + 16'd1;
                    end else begin
                        cnt_x <= cnt_x + 16'd1;
                    end
                end
            end
        end
    end

    logic signed [33:0]    sq_x, sq_y;
    logic [39:0]           prod_k, p_sh;
    logic [16:0]           fac_c;
    logic signed [34:0]    px_x, px_y;
    logic                  in_range;
    logic [AW-1:0]         rd_addr;

    always_comb begin
        sq_x     = 34'(s1_dx) * 34'(s1_dx);
        sq_y     = 34'(s1_dy) * 34'(s1_dy);
        prod_k   = {8'd0, s2_r2} * {32'd0, CORR_K1};
        p_sh     = prod_k >> K_SHIFT;
        fac_c    = (p_sh > 40'd65536) ? '0 : 17'(40'd65536 - p_sh);
        px_x     = 35'(s3_dx) * $signed({18'd0, s3_fac});
        px_y     = 35'(s3_dy) * $signed({18'd0, s3_fac});
        in_range = (s4_sx >= 0) && (int'(s4_sx) < WIDTH) &&
                   (s4_sy >= 0) && (int'(s4_sy) < HEIGHT);
        rd_addr  = in_range ? AW'(int'(s4_sy) * WIDTH + int'(s4_sx)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_dx  <= '0;
            s1_dy  <= '0;
            s2_dx  <= '0;
            s2_dy  <= '0;
            s2_r2  <= '0;
            s3_dx  <= '0;
            s3_dy  <= '0;
            s3_fac <= '0;
            s4_sx  <= '0;
            s4_sy  <= '0;
            pix_q  <= '0;
        end else if (advance) begin
            s1_dx  <= $signed({1'b0, ox}) - CX;
            s1_dy  <= $signed({1'b0, oy}) - CY;
            s2_dx  <= s1_dx;
            s2_dy  <= s1_dy;
            s2_r2  <= 32'(sq_x + sq_y);
            s3_dx  <= s2_dx;
            s3_dy  <= s2_dy;
            s3_fac <= fac_c;
            // Arithmetic shift floors negative offsets toward -inf.
            s4_sx  <= 18'(px_x >>> 16) + CX18;
            s4_sy  <= 18'(px_y >>> 16) + CY18;
            pix_q  <= in_range ? mem[rd_addr] : FILL;
        end
    end
endmodule
